// File: rtl/counter.sv
// Up-counter from 0 to MAX_VAL with a terminal-count flag. It wraps to 0 by default and saturates when COUNTER_SATURATE_EN is defined.
// Latency: an en sampled at edge N shows on count_out after edge N. tc is combinational from count_out.
// Backpressure: none. en=0, or an en that is not a clean 1, holds the count. Reset clears the count asynchronously.
module counter #(
    parameter int          WIDTH   = 4,
    parameter int unsigned MAX_VAL = (WIDTH >= 32) ? 32'hFFFF_FFFF
                                                   : 32'((64'd1 << WIDTH) - 64'd1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count_out,
    output logic             tc
);

    localparam longint unsigned FULL_SCALE = (64'd1 << WIDTH) - 64'd1;
    localparam logic [WIDTH-1:0] MAX_C     = MAX_VAL[WIDTH-1:0];

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("counter: WIDTH must be in 1..32");
    end
    if (MAX_VAL < 1 || 64'(MAX_VAL) > FULL_SCALE) begin : g_bad_max
        $error("counter: MAX_VAL must be in 1..2**WIDTH-1");
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // The count never exceeds MAX_C, so the else branch covers only count_q == MAX_C.
    always_comb begin
        count_d = count_q;
        if (en) begin
            if (count_q < MAX_C) begin
                count_d = count_q + WIDTH'(1);
            end else begin
`ifdef COUNTER_SATURATE_EN
                count_d = MAX_C;
`else
                count_d = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;
    assign tc        = (count_q == MAX_C);

endmodule

// File: tb/tb_counter.sv
// Randomized scoreboard bench for counter: the default 0..15 instance and a MAX_VAL=9 instance share stimulus.
module tb_counter;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       en    = 1'b0;
    logic [3:0] cnt15;
    logic       tc15;
    logic [3:0] cnt9;
    logic       tc9;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int c15;
        int c9;
        bit t15;
        bit t9;
    } exp_t;

    exp_t exp_q[$];
    int   m15 = 0;
    int   m9  = 0;

    counter dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .count_out(cnt15),
        .tc       (tc15)
    );

    counter #(.WIDTH(4), .MAX_VAL(9)) dut9 (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .count_out(cnt9),
        .tc       (tc9)
    );

    always #5 clk = ~clk;

    function automatic int nxt(int c, int maxv, bit e);
        if (!e) return c;
`ifdef COUNTER_SATURATE_EN
        return (c + 1 > maxv) ? maxv : c + 1;
`else
        return (c + 1) % (maxv + 1);
`endif
    endfunction

    function automatic void push(int c15, int c9);
        exp_t e;
        e.c15 = c15;
        e.c9  = c9;
        e.t15 = (c15 == 15);
        e.t9  = (c9 == 9);
        exp_q.push_back(e);
    endfunction

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, want);
        end
    endtask

    // One cycle: drive en at the falling edge. With rst_mid set, also pulse reset between that edge and the next rising edge.
    task automatic step(input bit e, input bit rst_mid);
        @(negedge clk);
        reset = 1'b0;
        en    = e;
        if (rst_mid) begin
            #2;
            push(0, 0);
            reset = 1'b1;
            m15 = 0;
            m9  = 0;
            push(0, 0);
        end else begin
            m15 = nxt(m15, 15, e);
            m9  = nxt(m9, 9, e);
            push(m15, m9);
        end
    endtask

    // Monitor: checks after every rising clock edge and every rising reset edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("count15", int'(cnt15), e.c15);
                chk("tc15",    int'(tc15),  int'(e.t15));
                chk("count9",  int'(cnt9),  e.c9);
                chk("tc9",     int'(tc9),   int'(e.t9));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        push(0, 0);
        reset = 1'b1;
        push(0, 0);
        #5;
        reset = 1'b0;
        repeat (4) step(1'b0, 1'b0);

        repeat (20) step(1'b1, 1'b0);

        step(1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        step(1'b0, 1'b1);
        repeat (9) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b0);

        // Reset released on the same edge where en is high: that edge must not count.
        @(negedge clk);
        en = 1'b1;
        push(0, 0);
        reset = 1'b1;
        m15 = 0;
        m9  = 0;
        push(0, 0);
        @(posedge clk);
        reset <= 1'b0;
        repeat (2) step(1'b1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
